// File: rtl/memory_reg_file.sv
// MIPS-style 32 x 32-bit register file: two combinational read ports, one
// synchronous write port, register 0 hardwired to zero.
module memory_reg_file #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we3,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];

  // Writes to address 0 are dropped, so regs_q[0] never leaves its reset value.
  always_comb begin
    regs_d = regs_q;
    if (we3 && (A3 != '0)) begin
      regs_d[A3] = WD3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // No write bypass: reads always see the stored contents.
  assign RD1 = (A1 == '0) ? '0 : regs_q[A1];
  assign RD2 = (A2 == '0) ? '0 : regs_q[A2];

endmodule

// File: tb/tb_memory_reg_file.sv
// Bench for memory_reg_file: directed scenarios with literal expectations plus
// randomized traffic checked against an array model every half cycle.
`timescale 1ns/1ps
module tb_memory_reg_file;

  logic        clk;
  logic        rst_n;
  logic        we3;
  logic [4:0]  A1, A2, A3;
  logic [31:0] WD3;
  logic [31:0] RD1, RD2;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  logic [31:0] mdl [32];

  memory_reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .we3  (we3),
    .A1   (A1),
    .A2   (A2),
    .A3   (A3),
    .WD3  (WD3),
    .RD1  (RD1),
    .RD2  (RD2)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : mdl[a];
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_cmp(input string tag);
    cmp({tag, "_rd1"}, RD1, model_rd(A1));
    cmp({tag, "_rd2"}, RD2, model_rd(A2));
  endtask

  // Model: contents vanish the instant reset asserts.
  always @(negedge rst_n) begin
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
  end

  // Single compare process: update model at the edge, check just after it and
  // again mid-low-phase once the negedge stimulus has settled.
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n === 1'b1 && we3 === 1'b1 && A3 != 5'd0) mdl[A3] = WD3;
      #1;
      if (chk_en) model_cmp("post_edge");
      @(negedge clk);
      #2;
      if (chk_en) model_cmp("pre_edge");
    end
  end

  task automatic expect_rd(input string name, input logic [31:0] e1, input logic [31:0] e2);
    cmp({name, "_rd1"}, RD1, e1);
    cmp({name, "_rd2"}, RD2, e2);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    rst_n = 0; we3 = 0; A1 = 0; A2 = 0; A3 = 0; WD3 = 0;
    chk_en = 1;

    // 1: reset state
    @(negedge clk); A1 = 5'd1; A2 = 5'd31;
    #2 expect_rd("t1_reset", 32'd0, 32'd0);
    @(negedge clk); rst_n = 1;

    // 2: write reg1, then retarget A3 to reg2 before next edge
    @(negedge clk); we3 = 1; A3 = 5'd1; WD3 = 32'h0000_F000; A1 = 5'd1; A2 = 5'd2;
    after_edge(); expect_rd("t2_w1", 32'h0000_F000, 32'd0);
    @(negedge clk); A3 = 5'd2;
    after_edge(); expect_rd("t2_w2", 32'h0000_F000, 32'h0000_F000);

    // 3: write to reg0 discarded
    @(negedge clk); A3 = 5'd0; WD3 = 32'hDEAD_BEEF; A1 = 5'd0; A2 = 5'd0;
    after_edge(); expect_rd("t3_r0", 32'd0, 32'd0);

    // 4: we3=0 blocks write, then enable
    @(negedge clk); we3 = 0; A3 = 5'd5; WD3 = 32'h1234_5678; A2 = 5'd5;
    after_edge(); expect_rd("t4_nowe", 32'd0, 32'd0);
    @(negedge clk); we3 = 1;
    after_edge(); expect_rd("t4_we", 32'd0, 32'h1234_5678);

    // 5: same-cycle read/write, no bypass
    @(negedge clk); A3 = 5'd7; A1 = 5'd7; WD3 = 32'hA5A5_A5A5;
    #2 expect_rd("t5_before", 32'd0, 32'h1234_5678);
    after_edge(); expect_rd("t5_after", 32'hA5A5_A5A5, 32'h1234_5678);

    // 6: fill regs 1..31, then asynchronous reset between edges
    for (int i = 1; i < 32; i++) begin
      @(negedge clk); we3 = 1; A3 = 5'(i); WD3 = 32'(i);
    end
    @(negedge clk); we3 = 0; A1 = 5'd31; A2 = 5'd16;
    #1 expect_rd("t6_filled", 32'd31, 32'd16);
    #2 rst_n = 0;
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i); A2 = 5'(31 - i);
      #0.05;
      expect_rd("t6_async_rst", 32'd0, 32'd0);
    end
    @(negedge clk); rst_n = 1;

    // Randomized traffic with occasional mid-cycle resets
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      we3 = ($urandom_range(0, 3) != 0);
      A3  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      WD3 = $urandom;
      A1  = ($urandom_range(0, 3) == 0) ? A3 : 5'($urandom);
      A2  = ($urandom_range(0, 5) == 0) ? A1 : 5'($urandom);
      if ($urandom_range(0, 63) == 0) begin
        #3 rst_n = 0;
        #1 expect_rd("rand_async_rst", 32'd0, 32'd0);
        @(negedge clk); rst_n = 1;
      end
    end

    @(negedge clk);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
